// File: rtl/regfile_pkg.sv
// Shared widths and FSM state encoding for the register-file burst controller.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_burst_ctrl.sv
// Burst read/write sequencer for a 1-cycle-latency register file; one beat per cycle.
// Writes are combinational pass-through; read beats appear the cycle after issue and stall on rdata_ready.
module regfile_burst_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,

    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,

    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,

    output logic                  done,

    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic [DATA_WIDTH-1:0] rf_rd_data
);

    localparam logic [LEN_WIDTH:0]  ONE_BEAT = (LEN_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH:0]    beats_q, beats_d;
    logic                  rvld_q,  rvld_d;
    logic                  rlast_q, rlast_d;
    logic                  done_q,  done_d;
    logic                  rd_hs;
    logic                  rd_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        rvld_d      = rvld_q;
        rlast_d     = rlast_q;
        done_d      = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        rf_wr_en    = 1'b0;
        rd_issue    = 1'b0;
        rd_hs       = rvld_q && rdata_ready;

        // A consumed beat retires unless a new issue below refills the slot.
        if (rd_hs) begin
            rvld_d  = 1'b0;
            rlast_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    beats_d = {1'b0, cmd_len} + ONE_BEAT;
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                rf_wr_en    = wdata_valid;
                if (wdata_valid) begin
                    addr_d  = addr_q + ADDR_ONE;
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                rd_issue = !rvld_q || rdata_ready;
                if (rd_issue) begin
                    addr_d  = addr_q + ADDR_ONE;
                    beats_d = beats_q - ONE_BEAT;
                    rvld_d  = 1'b1;
                    rlast_d = (beats_q == ONE_BEAT);
                    if (beats_q == ONE_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_hs && rlast_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_rd_en    = rd_issue;
    assign rf_addr     = addr_q;
    assign rf_wr_data  = wdata;
    assign rdata       = rf_rd_data;
    assign rdata_valid = rvld_q;
    assign rdata_last  = rlast_q;
    assign done        = done_q;

endmodule
